rr_mux_feeder: RTL and testbench

- Upstream stage of the 2:1 behavioural mux (ports IN[1:0], Select, output C).
- Accepts 1-bit samples from two independent producers over valid/ready handshakes, holding one sample per channel.
- Arbitrates between the two channels round-robin and presents a registered {IN, Select} word, with out_valid/out_ready, to the mux stage.
- The mux output C then equals the granted channel's sample.

---
 rtl/rr_mux_feeder_if.sv | 28 ++
 rtl/rr_mux_feeder.sv | 87 ++++++++
 tb/tb_rr_mux_feeder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_feeder_if.sv
// Handshake bundle between the two producers, the round-robin feeder and the
// downstream 2:1 mux stage.
//
// Valid/ready rule used on every channel here: a transfer happens at a rising
// clk edge where valid and ready are both high. A producer that raises valid
// keeps valid and data stable until that transfer edge. Ready does not depend
// on valid.
interface rr_mux_feeder_if;
  logic [1:0] in_valid;   // bit i: producer i offers in_data[i]
  logic [1:0] in_data;    // bit i: producer i sample
  logic [1:0] in_ready;   // bit i: channel i holding register empty
  logic       out_valid;  // IN/Select hold a granted sample
  logic       out_ready;  // downstream consumes the current word
  logic [1:0] IN;         // registered mux data inputs
  logic       Select;     // registered mux select (granted channel)

  // Producers plus downstream consumer side (testbench / surrounding logic)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, IN, Select
  );

  // Feeder side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, IN, Select
  );
endinterface

// File: rtl/rr_mux_feeder.sv
// Round-robin feeder for the 2:1 behavioural mux. Each channel has a one-sample
// holding register. When the output word is free, a full channel is granted
// (alternating when both are full), and a registered {IN, Select} word is
// presented so that the mux output C = IN[Select] is the granted sample.
module rr_mux_feeder (
  input  logic            clk,
  input  logic            rst_n,
  rr_mux_feeder_if.slave  bus
);

  logic [1:0] r_buf_full;
  logic [1:0] r_buf_data;
  logic       r_ptr;
  logic       r_out_valid;
  logic [1:0] r_in;
  logic       r_sel;

  logic       w_out_free;
  logic       w_any_full;
  logic       w_grant;
  logic       w_win;
  logic [1:0] w_load;
  logic [1:0] w_clear;
  logic [1:0] w_in_next;

  // The output register can take a new word when empty or being consumed.
  assign w_out_free = ~r_out_valid | bus.out_ready;
  assign w_any_full = |r_buf_full;
  assign w_grant    = w_out_free & w_any_full;

  // A channel loads only while its holding register is empty.
  assign w_load = bus.in_valid & ~r_buf_full;

  // Winner selection: the only full channel, or ptr when both are full.
  always_comb begin
    w_win = r_ptr;
    if (r_buf_full == 2'b01) begin
      w_win = 1'b0;
    end else if (r_buf_full == 2'b10) begin
      w_win = 1'b1;
    end
  end

  // The granted buffer is released; only one bit can be set.
  assign w_clear = w_grant ? (w_win ? 2'b10 : 2'b01) : 2'b00;

  // The winner is full by construction, so masking data with the full flags
  // gives the winner's sample in IN[w] and the other lane's sample or 0.
  assign w_in_next = r_buf_data & r_buf_full;

  // Holding registers: load on accept, release on grant. Accept needs the
  // buffer empty and grant needs it full, so both never hit the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full <= 2'b00;
      r_buf_data <= 2'b00;
    end else begin
      r_buf_full <= (r_buf_full & ~w_clear) | w_load;
      r_buf_data <= (r_buf_data & ~w_load) | (bus.in_data & w_load);
    end
  end

  // Output word and round-robin pointer; everything holds under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_in        <= 2'b00;
      r_sel       <= 1'b0;
      r_ptr       <= 1'b0;
    end else if (w_out_free) begin
      if (w_any_full) begin
        r_out_valid <= 1'b1;
        r_sel       <= w_win;
        r_in        <= w_in_next;
        r_ptr       <= ~w_win;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ~r_buf_full;
  assign bus.out_valid = r_out_valid;
  assign bus.IN        = r_in;
  assign bus.Select    = r_sel;

endmodule

// File: tb/tb_rr_mux_feeder.sv
// Directed and randomised bench for rr_mux_feeder: reset, single channel,
// contention/round-robin, back-pressure, asynchronous reset mid-operation,
// then a 2000-cycle random run against per-channel expected queues.
module tb_rr_mux_feeder;

  logic clk;
  logic rst_n;

  rr_mux_feeder_if bus ();

  rr_mux_feeder u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];
  logic [1:0] last_acc = 2'b00;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // {2'b00, in_ready[1:0], out_valid, IN[1:0], Select}
  function automatic logic [7:0] snap();
    return {2'b00, bus.in_ready, bus.out_valid, bus.IN, bus.Select};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver for one random cycle; pre-edge values are captured for scoring.
  task automatic sweep_step(input bit drain);
    logic [1:0] v;
    logic [1:0] d;
    logic [1:0] acc;
    logic [1:0] dat;
    logic       cons;
    logic       stall;
    logic [1:0] w_in;
    logic       w_sel;
    logic [0:0] e;
    v = bus.in_valid;
    d = bus.in_data;
    for (int i = 0; i < 2; i++) begin
      if (drain) begin
        v[i] = 1'b0;
      end else if (!(v[i] && !last_acc[i])) begin
        v[i] = ($urandom_range(0, 2) != 0);
        d[i] = 1'($urandom_range(0, 1));
      end
    end
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    #1;
    acc   = bus.in_valid & bus.in_ready;
    dat   = bus.in_data;
    cons  = bus.out_valid & bus.out_ready;
    stall = bus.out_valid & ~bus.out_ready;
    w_in  = bus.IN;
    w_sel = bus.Select;
    tick();
    last_acc = acc;
    if (acc[0]) exp_q0.push_back(dat[0]);
    if (acc[1]) exp_q1.push_back(dat[1]);
    if (cons) begin
      if (w_sel) begin
        check("sweep_nonempty", {7'b0, exp_q1.size() != 0}, 8'd1);
        e = (exp_q1.size() != 0) ? exp_q1.pop_front() : 1'bx;
      end else begin
        check("sweep_nonempty", {7'b0, exp_q0.size() != 0}, 8'd1);
        e = (exp_q0.size() != 0) ? exp_q0.pop_front() : 1'bx;
      end
      check("mux_c", {7'b0, w_in[w_sel]}, {7'b0, e});
    end
    if (stall) begin
      check("sweep_hold", {4'b0, bus.out_valid, bus.IN, bus.Select},
            {4'b0, 1'b1, w_in, w_sel});
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 2'b00;
    bus.in_data   = 2'b00;
    bus.out_ready = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", snap(), 8'b00_11_0_00_0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle", snap(), 8'b00_11_0_00_0);
    end

    // Single channel: channel 1 carries a 1
    bus.in_valid  = 2'b10;
    bus.in_data   = 2'b10;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 2'b00;
    check("single_load", snap(), 8'b00_01_0_00_0);
    tick();
    check("single_grant", snap(), 8'b00_11_1_10_1);
    check("single_mux_c", {7'b0, bus.IN[bus.Select]}, 8'd1);
    tick();
    check("single_drop", snap(), 8'b00_11_0_10_1);

    // Contention: ch0=1, ch1=0 loaded together
    bus.in_valid = 2'b11;
    bus.in_data  = 2'b01;
    tick();
    bus.in_valid = 2'b00;
    check("both_load", snap(), 8'b00_00_0_10_1);
    tick();
    check("rr_first_ch0", snap(), 8'b00_01_1_01_0);
    tick();
    check("rr_second_ch1", snap(), 8'b00_11_1_00_1);
    // Reload: ch0=0, ch1=1; ptr is back at 0
    bus.in_valid = 2'b11;
    bus.in_data  = 2'b10;
    tick();
    bus.in_valid = 2'b00;
    check("reload", snap(), 8'b00_00_0_00_1);
    tick();
    check("rr2_first_ch0", snap(), 8'b00_01_1_10_0);
    tick();
    check("rr2_second_ch1", snap(), 8'b00_11_1_10_1);
    tick();
    check("rr2_idle", snap(), 8'b00_11_0_10_1);

    // Back-pressure: word Select=1 IN=10 stalls while ch0 (data 0) is full
    bus.in_valid = 2'b10;
    bus.in_data  = 2'b10;
    tick();
    check("bp_ch1_load", snap(), 8'b00_01_0_10_1);
    bus.in_valid  = 2'b01;
    bus.in_data   = 2'b00;
    bus.out_ready = 1'b0;
    tick();
    check("bp_word", snap(), 8'b00_10_1_10_1);
    // Channel 0 now offers a 1 while full: must be ignored
    bus.in_data = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_frozen", snap(), 8'b00_10_1_10_1);
    end
    bus.in_valid  = 2'b00;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_ch0", snap(), 8'b00_11_1_00_0);
    tick();
    check("bp_idle", snap(), 8'b00_11_0_00_0);

    // Reset mid-operation with both buffers full and out_valid high
    bus.in_valid  = 2'b11;
    bus.in_data   = 2'b11;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 2'b00;
    check("mr_load_both", snap(), 8'b00_00_0_00_0);
    tick();
    check("mr_grant_ch1", snap(), 8'b00_10_1_11_1);
    bus.in_valid = 2'b10;
    bus.in_data  = 2'b11;
    tick();
    bus.in_valid = 2'b00;
    check("mr_full_valid", snap(), 8'b00_00_1_11_1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_async_clear", snap(), 8'b00_11_0_00_0);
    tick();
    check("mr_held", snap(), 8'b00_11_0_00_0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_stale", snap(), 8'b00_11_0_00_0);
    end

    // Random sweep, then drain
    last_acc = 2'b00;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      sweep_step(1'b0);
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      sweep_step(1'b1);
    end
    check("drain_q0_empty", 8'(exp_q0.size()), 8'd0);
    check("drain_q1_empty", 8'(exp_q1.size()), 8'd0);
    check("drain_idle", snap(), {2'b00, 2'b11, 1'b0, bus.IN, bus.Select});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
